divide_f32_sequencer: RTL and testbench

// - Request front-end for the iterative f32 divide unit. Buffers {num,den} jobs from a valid/ready

---
 rtl/divide_f32_sequencer_pkg.sv | 31 +++
 rtl/divide_f32_sequencer_fifo_sync.sv | 56 +++++
 rtl/divide_f32_sequencer.sv | 168 ++++++++++++++++
 tb/tb_divide_f32_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divide_f32_sequencer_pkg.sv
// Shared definitions for the f32 divide sequencer: field widths, IEEE-754 constants,
// FSM encoding and result flag positions.
package divide_f32_sequencer_pkg;

  localparam int WIDTH         = 32;
  localparam int EXPONENTWIDTH = 8;
  localparam int MANTISSAWIDTH = 23;

  localparam logic [WIDTH-1:0]         F32_QNAN    = 32'h7fc00000;
  localparam logic [EXPONENTWIDTH-1:0] F32_INF_EXP = 8'hff;

  localparam int FLAG_DEN_ZERO = 0;
  localparam int FLAG_TIMEOUT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // +/-0 regardless of sign bit
  function automatic logic f32_is_zero(input logic [WIDTH-1:0] x);
    return (x[WIDTH-2:0] == 31'd0);
  endfunction

  function automatic logic [WIDTH-1:0] f32_signed_inf(input logic sign);
    return {sign, F32_INF_EXP, {MANTISSAWIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/divide_f32_sequencer_fifo_sync.sv
// Synchronous job FIFO with async active-high reset. Pushes while full are dropped,
// pops while empty are ignored; head data is presented combinationally.
module divide_f32_sequencer_fifo_sync #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/divide_f32_sequencer.sv
// Request front-end for the iterative f32 divide unit: queues jobs, sequences the unit
// through a reset pulse and a bounded wait, and returns results in issue order.
module divide_f32_sequencer
  import divide_f32_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  output logic             div_rst,
  output logic [WIDTH-1:0] div_num,
  output logic [WIDTH-1:0] div_den,
  input  logic             div_rdy,
  input  logic [WIDTH-1:0] div_quo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quo,
  output logic [1:0]       out_flags,
  output logic [7:0]       out_cycles
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  seq_state_e         state_r;
  seq_state_e         state_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic [2*WIDTH-1:0] fifo_head_s;
  logic [WIDTH-1:0]   head_num_s;
  logic [WIDTH-1:0]   head_den_s;
  logic [7:0]         wait_cnt_r;
  logic               res_load_s;
  logic [WIDTH-1:0]   res_quo_s;
  logic [1:0]         res_flags_s;
  logic [7:0]         res_cycles_s;
  logic               div_rst_r;
  logic [WIDTH-1:0]   div_num_r;
  logic [WIDTH-1:0]   div_den_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   out_quo_r;
  logic [1:0]         out_flags_r;
  logic [7:0]         out_cycles_r;

  // in_ready is held low for the whole time reset is asserted
  assign in_ready    = !rst && !fifo_full_s;
  assign fifo_push_s = in_valid && in_ready;
  assign head_num_s  = fifo_head_s[2*WIDTH-1:WIDTH];
  assign head_den_s  = fifo_head_s[WIDTH-1:0];

  divide_f32_sequencer_fifo_sync #(
    .DEPTH (DEPTH),
    .DW    (2*WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .wdata ({in_num, in_den}),
    .pop   (fifo_pop_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // next state, pop strobe and result to capture
  always_comb begin
    state_s      = state_r;
    fifo_pop_s   = 1'b0;
    res_load_s   = 1'b0;
    res_quo_s    = '0;
    res_flags_s  = 2'b00;
    res_cycles_s = 8'd0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && !out_valid_r) begin
          fifo_pop_s = 1'b1;
          if (f32_is_zero(head_den_s)) begin
            // divide-by-zero never reaches the unit
            state_s    = ST_DONE;
            res_load_s = 1'b1;
            res_quo_s  = f32_is_zero(head_num_s) ? F32_QNAN
                                                 : f32_signed_inf(head_num_s[WIDTH-1] ^ head_den_s[WIDTH-1]);
            res_flags_s[FLAG_DEN_ZERO] = 1'b1;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: state_s = ST_WAIT;
      ST_WAIT: begin
        res_cycles_s = wait_cnt_r;
        if (div_rdy) begin
          state_s    = ST_DONE;
          res_load_s = 1'b1;
          res_quo_s  = div_quo;
        end else if (wait_cnt_r == LAST_WAIT) begin
          state_s    = ST_DONE;
          res_load_s = 1'b1;
          res_quo_s  = F32_QNAN;
          res_flags_s[FLAG_TIMEOUT] = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (out_ready) state_s = ST_IDLE;
        else           state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // unit operands, launch pulse, wait counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_rst_r    <= 1'b1;
      div_num_r    <= '0;
      div_den_r    <= '0;
      wait_cnt_r   <= 8'd0;
      out_valid_r  <= 1'b0;
      out_quo_r    <= '0;
      out_flags_r  <= 2'b00;
      out_cycles_r <= 8'd0;
    end else begin
      div_rst_r <= (state_s == ST_LOAD);
      if (fifo_pop_s) begin
        div_num_r <= head_num_s;
        div_den_r <= head_den_s;
      end
      if (state_r == ST_LOAD) begin
        wait_cnt_r <= 8'd0;
      end else if (state_r == ST_WAIT && wait_cnt_r != 8'hff) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end
      if (res_load_s) begin
        out_valid_r  <= 1'b1;
        out_quo_r    <= res_quo_s;
        out_flags_r  <= res_flags_s;
        out_cycles_r <= res_cycles_s;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign div_rst    = div_rst_r;
  assign div_num    = div_num_r;
  assign div_den    = div_den_r;
  assign out_valid  = out_valid_r;
  assign out_quo    = out_quo_r;
  assign out_flags  = out_flags_r;
  assign out_cycles = out_cycles_r;

endmodule

// File: tb/tb_divide_f32_sequencer.sv
// Directed bench for divide_f32_sequencer with a cycle-programmable divide unit model.
module tb_divide_f32_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_num;
  logic [31:0] in_den;
  logic        div_rst;
  logic [31:0] div_num;
  logic [31:0] div_den;
  logic        div_rdy;
  logic [31:0] div_quo;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quo;
  logic [1:0]  out_flags;
  logic [7:0]  out_cycles;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_pulse  = 0;
  int n_acc    = 0;

  logic [15:0] k_cyc;
  logic [15:0] mdl_cnt;

  logic [31:0] jn [6];
  logic [31:0] jd [6];
  logic [31:0] jq [6];
  logic [1:0]  jf [6];

  divide_f32_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_num     (in_num),
    .in_den     (in_den),
    .div_rst    (div_rst),
    .div_num    (div_num),
    .div_den    (div_den),
    .div_rdy    (div_rdy),
    .div_quo    (div_quo),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_quo    (out_quo),
    .out_flags  (out_flags),
    .out_cycles (out_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst && div_rst) n_pulse <= n_pulse + 1;

  // divide unit model: counts cycles since its reset, ready after k_cyc, rdy stays high
  always @(posedge clk) begin
    if (div_rst) mdl_cnt <= 16'd0;
    else if (mdl_cnt != 16'hffff) mdl_cnt <= mdl_cnt + 16'd1;
  end
  assign div_rdy = (mdl_cnt >= k_cyc);

  function automatic logic [31:0] model_div(input logic [31:0] n, input logic [31:0] d);
    case ({n, d})
      {32'h40c00000, 32'h40400000}: return 32'h40000000; // 6/3
      {32'h41000000, 32'h40000000}: return 32'h40800000; // 8/2
      {32'h3f800000, 32'h40000000}: return 32'h3f000000; // 1/2
      {32'h41100000, 32'h40400000}: return 32'h40400000; // 9/3
      {32'h41200000, 32'h40000000}: return 32'h40a00000; // 10/2
      default:                      return 32'hdeadbeef;
    endcase
  endfunction
  assign div_quo = model_div(div_num, div_den);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic push_job(input logic [31:0] n, input logic [31:0] d, output int acc_cyc);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_num   = n;
    in_den   = d;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("push_accept", in_ready, 1'b1);
    acc_cyc = cyc;
    n_acc++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] quo, input logic [1:0] flags,
                               input logic [7:0] cycles, output int seen);
    int t;
    t = 0;
    while (!out_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    seen = cyc;
    check_eq({tag, "_valid"},  out_valid,  1'b1);
    check_eq({tag, "_quo"},    out_quo,    quo);
    check_eq({tag, "_flags"},  out_flags,  flags);
    check_eq({tag, "_cycles"}, out_cycles, cycles);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n0;
    int seen;
    int p0;

    jn[0] = 32'h40c00000; jd[0] = 32'h40400000; jq[0] = 32'h40000000; jf[0] = 2'b00;
    jn[1] = 32'h41000000; jd[1] = 32'h40000000; jq[1] = 32'h40800000; jf[1] = 2'b00;
    jn[2] = 32'h3f800000; jd[2] = 32'h40000000; jq[2] = 32'h3f000000; jf[2] = 2'b00;
    jn[3] = 32'h41100000; jd[3] = 32'h40400000; jq[3] = 32'h40400000; jf[3] = 2'b00;
    jn[4] = 32'h41200000; jd[4] = 32'h40000000; jq[4] = 32'h40a00000; jf[4] = 2'b00;
    jn[5] = 32'h3f800000; jd[5] = 32'h80000000; jq[5] = 32'hff800000; jf[5] = 2'b01;

    rst = 1'b1; in_valid = 1'b0; in_num = 32'd0; in_den = 32'd0; out_ready = 1'b1;
    k_cyc = 16'd5;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready",   in_ready,   1'b0);
    check_eq("rst_div_rst",    div_rst,    1'b1);
    check_eq("rst_out_valid",  out_valid,  1'b0);
    check_eq("rst_out_quo",    out_quo,    32'd0);
    check_eq("rst_out_flags",  out_flags,  2'b00);
    check_eq("rst_out_cycles", out_cycles, 8'd0);
    check_eq("rst_div_num",    div_num,    32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);

    // 6/3 with K=5: launch timing and latency
    p0 = n_pulse;
    in_valid = 1'b1; in_num = 32'h40c00000; in_den = 32'h40400000; n0 = cyc;
    @(negedge clk); in_valid = 1'b0;
    check_eq("lat_pop_div_rst", div_rst, 1'b0);
    @(negedge clk);
    check_eq("lat_load_div_rst", div_rst, 1'b1);
    check_eq("lat_load_num", div_num, 32'h40c00000);
    check_eq("lat_load_den", div_den, 32'h40400000);
    @(negedge clk);
    check_eq("lat_wait_div_rst", div_rst, 1'b0);
    expect_result("div63", 32'h40000000, 2'b00, 8'd5, seen);
    check_eq("div63_latency", seen - n0, 9);
    check_eq("div63_one_pulse", n_pulse - p0, 1);

    // 1.0 / -0.0 handled locally
    p0 = n_pulse;
    push_job(32'h3f800000, 32'h80000000, n0);
    expect_result("zden", 32'hff800000, 2'b01, 8'd0, seen);
    check_eq("zden_latency", seen - n0, 2);
    check_eq("zden_no_pulse", n_pulse, p0);

    // 0/0
    push_job(32'h00000000, 32'h00000000, n0);
    expect_result("zero_zero", 32'h7fc00000, 2'b01, 8'd0, seen);

    // unit never answers
    k_cyc = 16'd1000;
    push_job(32'h41000000, 32'h40000000, n0);
    expect_result("tmo", 32'h7fc00000, 2'b10, 8'd63, seen);
    check_eq("tmo_latency", seen - n0, 67);

    // rdy on the last allowed WAIT cycle wins over the timeout
    k_cyc = 16'd63;
    push_job(32'h41000000, 32'h40000000, n0);
    expect_result("edge_rdy", 32'h40800000, 2'b00, 8'd63, seen);

    // rdy left high by the previous job must not finish this one early
    k_cyc = 16'd3;
    push_job(32'h3f800000, 32'h40000000, n0);
    expect_result("stale_rdy", 32'h3f000000, 2'b00, 8'd3, seen);

    // six back-to-back pushes against a stalled consumer
    k_cyc = 16'd2;
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        int a;
        for (int i = 0; i < 6; i++) push_job(jn[i], jd[i], a);
      end
      begin
        int s;
        repeat (12) @(negedge clk);
        check_eq("full_accepted", n_acc, 5);
        check_eq("full_in_ready", in_ready, 1'b0);
        check_eq("full_held_valid", out_valid, 1'b1);
        check_eq("full_held_quo", out_quo, 32'h40000000);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++)
          expect_result($sformatf("order%0d", i), jq[i], jf[i], (jf[i] == 2'b01) ? 8'd0 : 8'd2, s);
      end
    join

    // reset while the unit is busy, with jobs queued behind it
    k_cyc = 16'd1000;
    push_job(32'h40c00000, 32'h40400000, n0);
    push_job(32'h41000000, 32'h40000000, n0);
    push_job(32'h41100000, 32'h40400000, n0);
    repeat (8) @(negedge clk);
    check_eq("midrst_busy_div_rst", div_rst, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_div_rst",   div_rst,   1'b1);
    check_eq("midrst_in_ready",  in_ready,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst_fifo_empty", div_rst, 1'b0);
    end
    check_eq("midrst_no_result", out_valid, 1'b0);
    k_cyc = 16'd4;
    push_job(32'h41100000, 32'h40400000, n0);
    expect_result("after_rst", 32'h40400000, 2'b00, 8'd4, seen);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
